axis_to_vid_uhd_4ppc: RTL and testbench

// - Sink end of the UHD 4-pixel-per-clock AXI4-Stream video bus: accepts 96-bit RGB beats
//   (4 x 24 bit, pixel 0 in bits [23:0]) and emits them as timed parallel video.
// - Outputs are data, DE, HSYNC and VSYNC, ready for an HDMI/DVI encoder.
// - Sits after rgb2gray_uhd_4ppc or any other 4ppc processing stage.
// - Locks to the stream's start-of-frame and re-locks after any underflow or framing error.

---
 rtl/axis_to_vid_uhd_4ppc_pkg.sv | 26 ++
 rtl/axis_to_vid_uhd_4ppc_vid_timing_gen.sv | 67 ++++++
 rtl/axis_to_vid_uhd_4ppc.sv | 101 ++++++++++
 tb/tb_axis_to_vid_uhd_4ppc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_to_vid_uhd_4ppc_pkg.sv
// Shared timing defaults, beat width and lock-state encoding for the UHD 4ppc
// stream-to-video sink (CEA-861 3840x2160 at 30 Hz, four pixels per clock).
package axis_to_vid_uhd_4ppc_pkg;

  localparam int BEAT_W       = 96;
  localparam int H_ACTIVE_DEF = 960;
  localparam int H_FP_DEF     = 44;
  localparam int H_SYNC_DEF   = 22;
  localparam int H_BP_DEF     = 74;
  localparam int V_ACTIVE_DEF = 2160;
  localparam int V_FP_DEF     = 8;
  localparam int V_SYNC_DEF   = 10;
  localparam int V_BP_DEF     = 72;
  localparam logic SYNC_POL_DEF = 1'b1;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } lock_state_e;

  // Total length of a line or frame built from its four regions.
  function automatic int region_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/axis_to_vid_uhd_4ppc_vid_timing_gen.sv
// Free-running raster counters with region flags decoded from the current count.
// Region order within a line and within a frame is active, front porch, sync, back porch.
module vid_timing_gen
  import axis_to_vid_uhd_4ppc_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic eof_o,
  output logic sof_pos_o,
  output logic eol_pos_o
);

  localparam int H_TOT = region_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = region_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  int            h_pos, v_pos;
  logic          h_last, v_last;

  assign h_pos  = int'(h_cnt_q);
  assign v_pos  = int'(v_cnt_q);
  assign h_last = (h_pos == H_TOT - 1);
  assign v_last = (v_pos == V_TOT - 1);

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Sync flags are active-high here; polarity is applied at the output register.
  assign active_o  = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign hsync_o   = (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
  assign vsync_o   = (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);
  assign eof_o     = h_last && v_last;
  assign sof_pos_o = (h_pos == 0) && (v_pos == 0);
  assign eol_pos_o = (h_pos == H_ACTIVE - 1);

endmodule

// File: rtl/axis_to_vid_uhd_4ppc.sv
// AXI4-Stream 4ppc video sink: locks the incoming stream to the local raster and
// emits registered data/DE/HSYNC/VSYNC, dropping lock on underflow or framing error.
module axis_to_vid_uhd_4ppc
  import axis_to_vid_uhd_4ppc_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic              s_axis_video_aclk,
  input  logic              s_axis_video_aresetn,
  input  logic [BEAT_W-1:0] VIDEO_IN_tdata,
  input  logic              VIDEO_IN_tvalid,
  output logic              VIDEO_IN_tready,
  input  logic              VIDEO_IN_tuser,
  input  logic              VIDEO_IN_tlast,
  output logic [BEAT_W-1:0] vid_data,
  output logic              vid_de,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              locked,
  output logic              underflow,
  output logic              sync_err
);

  logic active, hsync, vsync, eof, sof_pos, eol_pos;

  vid_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i     (s_axis_video_aclk),
    .rst_ni    (s_axis_video_aresetn),
    .active_o  (active),
    .hsync_o   (hsync),
    .vsync_o   (vsync),
    .eof_o     (eof),
    .sof_pos_o (sof_pos),
    .eol_pos_o (eol_pos)
  );

  lock_state_e       state_q;
  logic [BEAT_W-1:0] data_q;
  logic              de_q, hsync_q, vsync_q, underflow_q, sync_err_q;
  logic              beat_taken, slot_missed, frame_bad, sof_held;

  // While waiting, everything except an SOF beat is drained; the SOF beat is
  // parked until the raster reaches its last slot so it lands on h=0, v=0.
  always_comb begin
    VIDEO_IN_tready = 1'b0;
    if (s_axis_video_aresetn) begin
      if (state_q == ST_RUN) VIDEO_IN_tready = active;
      else                   VIDEO_IN_tready = !(VIDEO_IN_tvalid && VIDEO_IN_tuser);
    end
  end

  assign beat_taken  = VIDEO_IN_tvalid && VIDEO_IN_tready;
  assign slot_missed = (state_q == ST_RUN) && active && !VIDEO_IN_tvalid;
  assign frame_bad   = (state_q == ST_RUN) && beat_taken &&
                       ((VIDEO_IN_tuser != sof_pos) || (VIDEO_IN_tlast != eol_pos));
  assign sof_held    = VIDEO_IN_tvalid && VIDEO_IN_tuser && eof;

  always_ff @(posedge s_axis_video_aclk) begin
    if (!s_axis_video_aresetn) begin
      state_q     <= ST_WAIT;
      data_q      <= '0;
      de_q        <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      data_q      <= ((state_q == ST_RUN) && beat_taken) ? VIDEO_IN_tdata : '0;
      de_q        <= active;
      hsync_q     <= hsync ^ ~SYNC_POL;
      vsync_q     <= vsync ^ ~SYNC_POL;
      underflow_q <= slot_missed;
      sync_err_q  <= frame_bad;
      case (state_q)
        ST_WAIT: if (sof_held) state_q <= ST_RUN;
        ST_RUN:  if (slot_missed || frame_bad) state_q <= ST_WAIT;
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign vid_data  = data_q;
  assign vid_de    = de_q;
  assign vid_hsync = hsync_q;
  assign vid_vsync = vsync_q;
  assign locked    = (state_q == ST_RUN);
  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_axis_to_vid_uhd_4ppc.sv
// Directed bench for axis_to_vid_uhd_4ppc using a reduced 8x6 raster
// (4 active clocks x 3 active lines), with a small raster model for expected timing.
module tb_axis_to_vid_uhd_4ppc;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [95:0] tdata = '0;
  logic        tvalid = 1'b0, tuser = 1'b0, tlast = 1'b0;
  logic        tready;
  logic [95:0] vid_data;
  logic        vid_de, vid_hsync, vid_vsync, locked, underflow, sync_err;

  axis_to_vid_uhd_4ppc #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .s_axis_video_aclk    (clk),
    .s_axis_video_aresetn (aresetn),
    .VIDEO_IN_tdata       (tdata),
    .VIDEO_IN_tvalid      (tvalid),
    .VIDEO_IN_tready      (tready),
    .VIDEO_IN_tuser       (tuser),
    .VIDEO_IN_tlast       (tlast),
    .vid_data             (vid_data),
    .vid_de               (vid_de),
    .vid_hsync            (vid_hsync),
    .vid_vsync            (vid_vsync),
    .locked               (locked),
    .underflow            (underflow),
    .sync_err             (sync_err)
  );

  always #5 clk = ~clk;

  int assertions = 0;
  int failures = 0;

  // Model raster position of the cycle about to be driven (th,tv) and of the
  // cycle whose registered outputs are currently visible (ph,pv).
  int   th = 0, tv = 0, ph = -1, pv = -1;
  logic acc, rdy, lk;
  int   deCount, hsCount, vsCount, ufCount, seCount;
  int   timingErr = 0, bpViol = 0, timeouts = 0;
  logic [95:0] dataLog[$];

  function automatic logic [95:0] beatData(input int n);
    logic [31:0] w;
    w = n;
    return {w, ~w, w};
  endfunction

  function automatic logic expActive(input int h, input int v);
    return (h < HA) && (v < VA);
  endfunction

  function automatic logic expHs(input int h);
    return (h >= HA + HF) && (h < HA + HF + HS);
  endfunction

  function automatic logic expVs(input int v);
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  task automatic clearStats();
    deCount = 0; hsCount = 0; vsCount = 0; ufCount = 0; seCount = 0;
    dataLog.delete();
  endtask

  // One clock: drive inputs, sample handshake mid-cycle, then observe the
  // registered outputs 1 ns after the edge.
  task automatic cycle(input logic v, input logic u, input logic l, input logic [95:0] d);
    logic inReset;
    tvalid = v; tuser = u; tlast = l; tdata = d;
    #4;
    rdy = tready; lk = locked; acc = v & tready; inReset = !aresetn;
    if (!inReset && lk === 1'b1 && !expActive(th, tv) && rdy !== 1'b0) bpViol++;
    @(posedge clk); #1;
    if (inReset) begin
      ph = -1; pv = -1; th = 0; tv = 0;
    end else begin
      ph = th; pv = tv;
      th++;
      if (th == HT) begin
        th = 0;
        tv = (tv == VT - 1) ? 0 : tv + 1;
      end
      if (vid_de !== expActive(ph, pv) || vid_hsync !== expHs(ph) || vid_vsync !== expVs(pv))
        timingErr++;
      if (vid_hsync === 1'b1) hsCount++;
      if (vid_vsync === 1'b1) vsCount++;
      if (lk === 1'b1 && vid_de === 1'b1) begin
        deCount++;
        dataLog.push_back(vid_data);
      end
      if (underflow === 1'b1) ufCount++;
      if (sync_err === 1'b1) seCount++;
    end
  endtask

  task automatic sendBeat(input logic [95:0] d, input logic u, input logic l,
                          output int ah, output int av, output logic alk, output logic [95:0] od);
    int n;
    n = 0; ah = -1; av = -1; alk = 1'b0; od = '0;
    do begin
      cycle(1'b1, u, l, d);
      n++;
    end while (!acc && n < 4 * HT * VT);
    if (acc) begin
      ah = ph; av = pv; alk = lk; od = vid_data;
    end else begin
      timeouts++;
    end
  endtask

  task automatic sendFrame(input int base, output int sh, output int sv,
                           output logic slk, output logic [95:0] sd);
    int ah, av;
    logic alk;
    logic [95:0] od;
    sh = -1; sv = -1; slk = 1'b0; sd = '0;
    for (int i = 0; i < HA * VA; i++) begin
      sendBeat(beatData(base + i), i == 0, (i % HA) == HA - 1, ah, av, alk, od);
      if (i == 0) begin
        sh = ah; sv = av; slk = alk; sd = od;
      end
    end
  endtask

  task automatic idleToFrameEnd();
    int n;
    n = 0;
    while (!(th == 0 && tv == 0) && n < HT * VT) begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      n++;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, beatData(999));
    cycle(1'b1, 1'b1, 1'b0, beatData(999));
    assertions++; if (rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_tready: got %b expected 0", rdy); end
    assertions++; if (vid_data !== 96'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0", vid_data); end
    assertions++; if (vid_de !== 1'b0) begin failures++; $display("[TB] FAIL reset_de: got %b expected 0", vid_de); end
    assertions++; if (vid_hsync !== 1'b0 || vid_vsync !== 1'b0) begin failures++; $display("[TB] FAIL reset_sync: got hs=%b vs=%b expected 0 0", vid_hsync, vid_vsync); end
    assertions++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    assertions++; if (underflow !== 1'b0 || sync_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses: got uf=%b se=%b expected 0 0", underflow, sync_err); end
    aresetn = 1'b1;
  endtask

  task automatic test_lock();
    int drops, early, sh, sv;
    logic slk;
    logic [95:0] sd;
    drops = 0; early = 0;
    clearStats();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, beatData(200 + i));
      if (acc) drops++;
      if (lk !== 1'b0) early++;
    end
    assertions++; if (drops !== 5) begin failures++; $display("[TB] FAIL lock_drops: got %0d expected 5", drops); end
    assertions++; if (early !== 0) begin failures++; $display("[TB] FAIL lock_early: got %0d locked cycles expected 0", early); end
    clearStats();
    sendFrame(1, sh, sv, slk, sd);
    idleToFrameEnd();
    assertions++; if (sh !== 0 || sv !== 0) begin failures++; $display("[TB] FAIL lock_sof_pos: got h=%0d v=%0d expected h=0 v=0", sh, sv); end
    assertions++; if (slk !== 1'b1) begin failures++; $display("[TB] FAIL lock_rise: got locked=%b at SOF expected 1", slk); end
    assertions++; if (sd !== beatData(1)) begin failures++; $display("[TB] FAIL lock_first_data: got %h expected %h", sd, beatData(1)); end
    assertions++; if (deCount !== 12) begin failures++; $display("[TB] FAIL lock_de_count: got %0d expected 12", deCount); end
  endtask

  task automatic test_steady();
    int sh, sv, bad;
    logic slk;
    logic [95:0] sd;
    bad = 0;
    clearStats();
    sendFrame(13, sh, sv, slk, sd);
    sendFrame(25, sh, sv, slk, sd);
    sendFrame(37, sh, sv, slk, sd);
    idleToFrameEnd();
    for (int i = 0; i < dataLog.size(); i++)
      if (dataLog[i] !== beatData(13 + i)) bad++;
    assertions++; if (dataLog.size() !== 36) begin failures++; $display("[TB] FAIL steady_beats: got %0d expected 36", dataLog.size()); end
    assertions++; if (bad !== 0) begin failures++; $display("[TB] FAIL steady_data: got %0d wrong beats expected 0", bad); end
    assertions++; if (hsCount !== 36) begin failures++; $display("[TB] FAIL steady_hsync_cycles: got %0d expected 36", hsCount); end
    assertions++; if (vsCount !== 24) begin failures++; $display("[TB] FAIL steady_vsync_cycles: got %0d expected 24", vsCount); end
    assertions++; if (timingErr !== 0) begin failures++; $display("[TB] FAIL steady_timing: got %0d bad cycles expected 0", timingErr); end
    assertions++; if (bpViol !== 0) begin failures++; $display("[TB] FAIL steady_blank_ready: got %0d ready blanking cycles expected 0", bpViol); end
    assertions++; if (ufCount !== 0 || seCount !== 0) begin failures++; $display("[TB] FAIL steady_errors: got uf=%0d se=%0d expected 0 0", ufCount, seCount); end
    assertions++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL steady_locked: got %b expected 1", locked); end
  endtask

  task automatic test_underflow();
    int ah, av, sh, sv;
    logic alk, slk;
    logic [95:0] od, sd;
    clearStats();
    for (int i = 0; i < 6; i++)
      sendBeat(beatData(50 + i), i == 0, (i % HA) == HA - 1, ah, av, alk, od);
    cycle(1'b0, 1'b0, 1'b0, '0);
    assertions++; if (ph !== 2 || pv !== 1) begin failures++; $display("[TB] FAIL uf_slot: got h=%0d v=%0d expected h=2 v=1", ph, pv); end
    assertions++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL uf_pulse: got %b expected 1", underflow); end
    assertions++; if (vid_data !== 96'h0 || vid_de !== 1'b1) begin failures++; $display("[TB] FAIL uf_data: got de=%b data=%h expected de=1 data=0", vid_de, vid_data); end
    assertions++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL uf_unlock: got %b expected 0", locked); end
    for (int i = 7; i < 12; i++)
      sendBeat(beatData(50 + i), 1'b0, (i % HA) == HA - 1, ah, av, alk, od);
    sendFrame(60, sh, sv, slk, sd);
    idleToFrameEnd();
    assertions++; if (sh !== 0 || sv !== 0 || slk !== 1'b1) begin failures++; $display("[TB] FAIL uf_relock: got h=%0d v=%0d locked=%b expected 0 0 1", sh, sv, slk); end
    assertions++; if (sd !== beatData(60)) begin failures++; $display("[TB] FAIL uf_relock_data: got %h expected %h", sd, beatData(60)); end
    assertions++; if (ufCount !== 1) begin failures++; $display("[TB] FAIL uf_count: got %0d expected 1", ufCount); end
  endtask

  task automatic test_framing();
    int ah, av, sh, sv;
    logic alk, slk;
    logic [95:0] od, sd;
    clearStats();
    sendBeat(beatData(70), 1'b1, 1'b0, ah, av, alk, od);
    sendBeat(beatData(71), 1'b0, 1'b0, ah, av, alk, od);
    sendBeat(beatData(72), 1'b0, 1'b1, ah, av, alk, od);
    assertions++; if (sync_err !== 1'b1) begin failures++; $display("[TB] FAIL tlast_err: got %b expected 1", sync_err); end
    assertions++; if (vid_data !== beatData(72)) begin failures++; $display("[TB] FAIL tlast_data: got %h expected %h", vid_data, beatData(72)); end
    assertions++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL tlast_unlock: got %b expected 0", locked); end
    sendFrame(80, sh, sv, slk, sd);
    idleToFrameEnd();
    assertions++; if (sh !== 0 || sv !== 0 || slk !== 1'b1) begin failures++; $display("[TB] FAIL tlast_relock: got h=%0d v=%0d locked=%b expected 0 0 1", sh, sv, slk); end
    sendBeat(beatData(90), 1'b0, 1'b0, ah, av, alk, od);
    assertions++; if (ah !== 0 || av !== 0) begin failures++; $display("[TB] FAIL tuser_slot: got h=%0d v=%0d expected 0 0", ah, av); end
    assertions++; if (sync_err !== 1'b1 || locked !== 1'b0) begin failures++; $display("[TB] FAIL tuser_err: got se=%b locked=%b expected 1 0", sync_err, locked); end
    assertions++; if (od !== beatData(90)) begin failures++; $display("[TB] FAIL tuser_data: got %h expected %h", od, beatData(90)); end
    assertions++; if (seCount !== 2 || ufCount !== 0) begin failures++; $display("[TB] FAIL framing_counts: got se=%0d uf=%0d expected 2 0", seCount, ufCount); end
  endtask

  task automatic test_reset_midline();
    int ah, av, n;
    logic alk;
    logic [95:0] od;
    sendBeat(beatData(100), 1'b1, 1'b0, ah, av, alk, od);
    for (int i = 1; i < 6; i++)
      sendBeat(beatData(100 + i), 1'b0, (i % HA) == HA - 1, ah, av, alk, od);
    assertions++; if (locked !== 1'b1 || th !== 2 || tv !== 1) begin failures++; $display("[TB] FAIL rst_setup: got locked=%b h=%0d v=%0d expected 1 2 1", locked, th, tv); end
    aresetn = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, beatData(106));
    aresetn = 1'b1;
    assertions++; if (rdy !== 1'b0) begin failures++; $display("[TB] FAIL rst_inflight: got tready=%b expected 0", rdy); end
    assertions++; if (vid_data !== 96'h0 || vid_de !== 1'b0) begin failures++; $display("[TB] FAIL rst_video: got de=%b data=%h expected 0 0", vid_de, vid_data); end
    assertions++; if (vid_hsync !== 1'b0 || vid_vsync !== 1'b0) begin failures++; $display("[TB] FAIL rst_sync: got hs=%b vs=%b expected 0 0", vid_hsync, vid_vsync); end
    assertions++; if (locked !== 1'b0 || underflow !== 1'b0 || sync_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_status: got locked=%b uf=%b se=%b expected 0 0 0", locked, underflow, sync_err); end
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0, '0);
      n++;
    end while (vid_hsync !== 1'b1 && n < 20);
    assertions++; if (n !== 6) begin failures++; $display("[TB] FAIL rst_counters: got first hsync after %0d cycles expected 6", n); end
    assertions++; if (timingErr !== 0 || bpViol !== 0 || timeouts !== 0) begin failures++; $display("[TB] FAIL run_totals: got timing=%0d blank_ready=%0d timeouts=%0d expected 0 0 0", timingErr, bpViol, timeouts); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_steady();
    test_underflow();
    test_framing();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
